// File: rtl/regfile_arbiter.sv
// Register file arbiter: shares one 16x32 register file (r0 reads as zero,
// 1-cycle registered reads, active-low enables) between the core pipeline
// (two reads or one write) and the debug module (one read or one write).
// Each access is accepted in IDLE or RESP, drives the register file for one
// ISSUE cycle and completes in the following RESP cycle.
module regfile_arbiter #(
    parameter int          DEBUG_PRIORITY = 1,
    parameter int unsigned MAX_WAIT       = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        core_valid,
    output logic        core_ready,
    input  logic        core_write,
    input  logic [3:0]  core_addr_a,
    input  logic [3:0]  core_addr_b,
    input  logic [31:0] core_wdata,
    output logic        core_resp_valid,
    output logic [31:0] core_rdata_a,
    output logic [31:0] core_rdata_b,

    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_write,
    input  logic [3:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_resp_valid,
    output logic [31:0] dbg_rdata,

    output logic        rf_write_en_n,
    output logic [3:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        rf_read_en_n,
    output logic [3:0]  rf_read_addr_a,
    output logic [3:0]  rf_read_addr_b,
    input  logic [31:0] rf_read_data_a,
    input  logic [31:0] rf_read_data_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    localparam bit         DBG_HI  = (DEBUG_PRIORITY != 0);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t      state_q,  state_d;
    owner_t      owner_q,  owner_d;
    logic        write_q,  write_d;
    logic [3:0]  addr_a_q, addr_a_d;
    logic [3:0]  addr_b_q, addr_b_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  starve_q, starve_d;

    logic arb_en;
    logic hi_valid;
    logic lo_valid;
    logic lo_forced;
    logic grant_hi;
    logic grant_lo;
    logic core_grant;
    logic dbg_grant;

    // Fixed-priority arbitration with the starvation guard; only IDLE and RESP arbitrate.
    always_comb begin
        arb_en     = (state_q == ST_IDLE) || (state_q == ST_RESP);
        hi_valid   = DBG_HI ? dbg_valid  : core_valid;
        lo_valid   = DBG_HI ? core_valid : dbg_valid;
        lo_forced  = (starve_q == WAIT_MAX);
        grant_lo   = arb_en && lo_valid && (!hi_valid || lo_forced);
        grant_hi   = arb_en && hi_valid && !(lo_valid && lo_forced);
        core_grant = DBG_HI ? grant_lo : grant_hi;
        dbg_grant  = DBG_HI ? grant_hi : grant_lo;
    end

    // Starvation counter: counts refused cycles of the lower-priority side, saturating.
    always_comb begin
        starve_d = starve_q;
        if (grant_lo) begin
            starve_d = '0;
        end else if (arb_en && lo_valid && (starve_q != WAIT_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Next-state sequencing and request capture on accept.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE:  if (core_grant || dbg_grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = (core_grant || dbg_grant) ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (dbg_grant) begin
            owner_d  = OWN_DBG;
            write_d  = dbg_write;
            addr_a_d = dbg_addr;
            addr_b_d = dbg_addr;
            wdata_d  = dbg_wdata;
        end else if (core_grant) begin
            owner_d  = OWN_CORE;
            write_d  = core_write;
            addr_a_d = core_addr_a;
            addr_b_d = core_addr_b;
            wdata_d  = core_wdata;
        end
    end

    // State, latched request and starvation counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_CORE;
            write_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    // Register file drive: enables only in ISSUE; writes to r0 are dropped.
    always_comb begin
        rf_write_en_n  = !((state_q == ST_ISSUE) && write_q && (addr_a_q != 4'd0));
        rf_read_en_n   = !((state_q == ST_ISSUE) && !write_q);
        rf_write_addr  = addr_a_q;
        rf_write_data  = wdata_q;
        rf_read_addr_a = addr_a_q;
        rf_read_addr_b = addr_b_q;
    end

    // Handshake and response outputs; read data gated to zero except the owner's read RESP.
    always_comb begin
        core_ready      = core_grant;
        dbg_ready       = dbg_grant;
        core_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_CORE);
        dbg_resp_valid  = (state_q == ST_RESP) && (owner_q == OWN_DBG);
        core_rdata_a    = '0;
        core_rdata_b    = '0;
        dbg_rdata       = '0;
        if (core_resp_valid && !write_q) begin
            core_rdata_a = rf_read_data_a;
            core_rdata_b = rf_read_data_b;
        end
        if (dbg_resp_valid && !write_q) begin
            dbg_rdata = rf_read_data_a;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register file,
// a reference register model and an in-order response scoreboard.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_valid, core_ready, core_write;
    logic [3:0]  core_addr_a, core_addr_b;
    logic [31:0] core_wdata;
    logic        core_resp_valid;
    logic [31:0] core_rdata_a, core_rdata_b;
    logic        dbg_valid, dbg_ready, dbg_write;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_resp_valid;
    logic [31:0] dbg_rdata;
    logic        rf_write_en_n, rf_read_en_n;
    logic [3:0]  rf_write_addr, rf_read_addr_a, rf_read_addr_b;
    logic [31:0] rf_write_data;
    logic [31:0] rf_read_data_a = '0;
    logic [31:0] rf_read_data_b = '0;

    regfile_arbiter #(.DEBUG_PRIORITY(1), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_valid(core_valid), .core_ready(core_ready), .core_write(core_write),
        .core_addr_a(core_addr_a), .core_addr_b(core_addr_b), .core_wdata(core_wdata),
        .core_resp_valid(core_resp_valid), .core_rdata_a(core_rdata_a), .core_rdata_b(core_rdata_b),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_write(dbg_write),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata),
        .rf_write_en_n(rf_write_en_n), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_read_en_n(rf_read_en_n), .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dbg;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    int    checks = 0;
    int    passes = 0;
    int    cyc    = 0;
    exp_t  scb[$];
    int    glog_cyc[$];
    bit    glog_dbg[$];
    logic [31:0] rf_mem  [16] = '{default: '0};
    logic [31:0] ref_mem [16] = '{default: '0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file: r0 reads zero, registered reads.
    always @(posedge clk) begin
        if (!rf_write_en_n && rf_write_addr != 4'd0) rf_mem[rf_write_addr] <= rf_write_data;
        if (!rf_read_en_n) begin
            rf_read_data_a <= (rf_read_addr_a == 4'd0) ? 32'd0 : rf_mem[rf_read_addr_a];
            rf_read_data_b <= (rf_read_addr_b == 4'd0) ? 32'd0 : rf_mem[rf_read_addr_b];
        end
    end

    // Monitor: checks responses against the scoreboard, records accepts.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            scb.delete();
        end else begin
            chk("en_exclusive", {63'd0, rf_write_en_n | rf_read_en_n}, 64'd1);
            chk("ready_exclusive", {63'd0, core_ready & dbg_ready}, 64'd0);
            if (core_resp_valid || dbg_resp_valid) begin
                chk("resp_expected", {63'd0, scb.size() != 0}, 64'd1);
                if (scb.size() != 0) begin
                    e = scb.pop_front();
                    chk("resp_owner", {62'd0, core_resp_valid, dbg_resp_valid},
                        e.dbg ? 64'd1 : 64'd2);
                    if (e.dbg) begin
                        chk("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, e.a});
                        chk("core_rdata_gated", {core_rdata_a, core_rdata_b}, 64'd0);
                    end else begin
                        chk("core_rdata", {core_rdata_a, core_rdata_b}, {e.a, e.b});
                        chk("dbg_rdata_gated", {32'd0, dbg_rdata}, 64'd0);
                    end
                end
            end else begin
                chk("rdata_idle_zero", {32'd0, core_rdata_a | core_rdata_b | dbg_rdata}, 64'd0);
            end
            if (core_valid && core_ready) begin
                if (core_write) begin
                    if (core_addr_a != 4'd0) ref_mem[core_addr_a] = core_wdata;
                    scb.push_back('{dbg: 1'b0, a: 32'd0, b: 32'd0});
                end else begin
                    scb.push_back('{dbg: 1'b0, a: ref_mem[core_addr_a], b: ref_mem[core_addr_b]});
                end
                glog_cyc.push_back(cyc);
                glog_dbg.push_back(1'b0);
            end
            if (dbg_valid && dbg_ready) begin
                if (dbg_write) begin
                    if (dbg_addr != 4'd0) ref_mem[dbg_addr] = dbg_wdata;
                    scb.push_back('{dbg: 1'b1, a: 32'd0, b: 32'd0});
                end else begin
                    scb.push_back('{dbg: 1'b1, a: ref_mem[dbg_addr], b: 32'd0});
                end
                glog_cyc.push_back(cyc);
                glog_dbg.push_back(1'b1);
            end
        end
    end

    // Present a request (called just after a rising edge); returns #1 into the ISSUE cycle.
    task automatic req(input bit dbg, input bit wr, input logic [3:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        int n = 0;
        if (dbg) begin
            dbg_valid = 1'b1; dbg_write = wr; dbg_addr = a; dbg_wdata = d;
        end else begin
            core_valid = 1'b1; core_write = wr; core_addr_a = a; core_addr_b = b; core_wdata = d;
        end
        forever begin
            @(negedge clk);
            if (dbg ? dbg_ready : core_ready) break;
            n++;
            if (n > 40) break;
        end
        chk("accept_timeout", {63'd0, n > 40}, 64'd0);
        @(posedge clk); #1;
        core_valid = 1'b0;
        dbg_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (scb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, n >= 40}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        reset_n = 1'b0;
        core_valid = 1'b0; core_write = 1'b0; core_addr_a = '0; core_addr_b = '0; core_wdata = '0;
        dbg_valid = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {58'd0, core_ready, dbg_ready, core_resp_valid, dbg_resp_valid,
                           rf_write_en_n, rf_read_en_n}, 64'h3);
        chk("reset_rdata", {32'd0, core_rdata_a | core_rdata_b | dbg_rdata}, 64'd0);
        chk("reset_rf_addr", {52'd0, rf_write_addr, rf_read_addr_a, rf_read_addr_b}, 64'd0);
        chk("reset_rf_data", {32'd0, rf_write_data}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Core write r5, then core read r5/r0 accepted in RESP.
        req(1'b0, 1'b1, 4'd5, 4'd0, 32'hDEADBEEF);
        chk("w5_issue_en", {62'd0, rf_write_en_n, rf_read_en_n}, 64'h1);
        chk("w5_issue_addr", {60'd0, rf_write_addr}, 64'd5);
        chk("w5_issue_data", {32'd0, rf_write_data}, 64'hDEADBEEF);
        @(posedge clk); #1;
        chk("w5_resp", {63'd0, core_resp_valid}, 64'd1);
        req(1'b0, 1'b0, 4'd5, 4'd0, 32'd0);
        chk("r5_issue_en", {62'd0, rf_write_en_n, rf_read_en_n}, 64'h2);
        chk("r5_issue_addr", {56'd0, rf_read_addr_a, rf_read_addr_b}, 64'h50);
        drain();

        // Debug write to r0 is dropped but still responds; read back r0.
        req(1'b1, 1'b1, 4'd0, 4'd0, 32'h1234);
        chk("dw0_issue_en", {62'd0, rf_write_en_n, rf_read_en_n}, 64'h3);
        @(posedge clk); #1;
        chk("dw0_resp", {62'd0, dbg_resp_valid, rf_write_en_n}, 64'h3);
        req(1'b1, 1'b0, 4'd0, 4'd0, 32'd0);
        drain();

        // Core-only requests: ready offered in IDLE, no starvation count builds.
        core_valid = 1'b1; core_write = 1'b0; core_addr_a = 4'd5; core_addr_b = 4'd5;
        @(negedge clk);
        chk("core_only_ready", {62'd0, core_ready, dbg_ready}, 64'h2);
        @(posedge clk); #1;
        core_valid = 1'b0;
        drain();
        req(1'b0, 1'b0, 4'd0, 4'd5, 32'd0);
        drain();
        req(1'b0, 1'b0, 4'd5, 4'd0, 32'd0);
        drain();

        // Simultaneous requests: 4 debug grants, then the core, one grant per 2 cycles.
        base = glog_dbg.size();
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 4'd5;
        core_valid = 1'b1; core_write = 1'b0; core_addr_a = 4'd5; core_addr_b = 4'd0;
        n = 0;
        while (glog_dbg.size() < base + 10 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        dbg_valid = 1'b0; core_valid = 1'b0;
        chk("tie_timeout", {63'd0, n >= 60}, 64'd0);
        if (glog_dbg.size() >= base + 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("tie_winner_%0d", i), {63'd0, glog_dbg[base + i]},
                    (i % 5 == 4) ? 64'd0 : 64'd1);
                if (i > 0)
                    chk($sformatf("tie_spacing_%0d", i),
                        64'(glog_cyc[base + i] - glog_cyc[base + i - 1]), 64'd2);
            end
        end
        drain();

        // Back-to-back write r3=7 then read r3 accepted in RESP.
        req(1'b0, 1'b1, 4'd3, 4'd0, 32'd7);
        @(posedge clk); #1;
        req(1'b0, 1'b0, 4'd3, 4'd3, 32'd0);
        chk("b2b_spacing", 64'(glog_cyc[$] - glog_cyc[$ - 1]), 64'd2);
        drain();

        // Reset during ISSUE of a core read drops the access.
        req(1'b0, 1'b0, 4'd5, 4'd3, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", {58'd0, core_ready, dbg_ready, core_resp_valid, dbg_resp_valid,
                            rf_write_en_n, rf_read_en_n}, 64'h3);
        chk("midrst_rdata", {32'd0, core_rdata_a | core_rdata_b | dbg_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet_%0d", i),
                {60'd0, rf_write_en_n, rf_read_en_n, core_resp_valid, dbg_resp_valid}, 64'hC);
        end
        @(posedge clk); #1;
        req(1'b0, 1'b0, 4'd3, 4'd5, 32'd0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
